i_type_lsu_mc: RTL and testbench

//  Multi-cycle, parametrised I-type execution unit. Holds its own register file
//  and word-addressed data memory; executes LW, SW and ADDI under a start/ready/done

---
 rtl/i_type_pkg.sv | 35 +++
 rtl/i_type_regfile.sv | 41 ++++
 rtl/i_type_lsu_mc.sv | 151 +++++++++++++++
 tb/tb_i_type_lsu_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i_type_pkg.sv
// Shared definitions for the multi-cycle I-type load/store/ADDI unit:
// opcode encodings, FSM state encoding and an immediate sign-extender.
package i_type_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    // Widest word the sign-extender can produce; callers cast down to their width.
    localparam int SEXT_W = 64;

    // Replicates bit [width-1] of val into every bit above it.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                               input int unsigned       width);
        logic [SEXT_W-1:0] res;
        logic [5:0]        sign_idx;
        logic              sign;
        res      = val;
        sign_idx = 6'(width - 1);
        sign     = val[sign_idx];
        for (int i = 0; i < SEXT_W; i++) begin
            if (i >= int'(width)) res[i] = sign;
        end
        return res;
    endfunction

endpackage

// File: rtl/i_type_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// R0 always reads as zero and ignores writes; synchronous active-low clear.
//   clk, rst_n            clock, synchronous active-low clear of all registers
//   raddr_a_i/rdata_a_o   read port A
//   raddr_b_i/rdata_b_o   read port B
//   we_i/waddr_i/wdata_i  write port, takes effect on the rising edge
module i_type_regfile
    import i_type_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is checked first inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/i_type_lsu_mc.sv
// Multi-cycle I-type execution unit (LW, SW, ADDI) with private register file
// and word-addressed data memory. Walks IDLE->RD->EX->MEM->WB for every opcode.
//   clk, rst_n      clock, synchronous active-low reset
//   start / ready   instruction handshake, accepted when both are high
//   OpCode, rs, rt, imm   instruction fields, sampled at accept only
//   datars / datart R[rs] / R[rt] as read; datart shows the written value after WB
//   done / err      one-cycle completion pulse and its error qualifier
module i_type_lsu_mc
    import i_type_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [5:0]        OpCode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] datars,
    output logic [DATA_W-1:0] datart,
    output logic              done,
    output logic              err
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e            state_q, state_d;
    logic [5:0]        op_q;
    logic [REG_AW-1:0] rs_q, rt_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] datars_q, datart_q, ea_q;
    logic              err_q;

    logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, mem_rdata;
    logic [MEM_AW-1:0] mem_idx;
    logic              is_lw, is_sw, is_addi, mem_fault, mem_we, rf_we;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RD;
            ST_RD:   state_d = ST_EX;
            ST_EX:   state_d = ST_MEM;
            ST_MEM:  state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = (state_q == ST_WB);
        err   = (state_q == ST_WB) && err_q;
    end

    // ---------------- decode and fault detection ----------------
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_addi = (op_q == OP_ADDI);
    // Only memory opcodes can go out of range; anything undecoded is illegal.
    assign mem_fault = !(is_lw || is_sw || is_addi) ||
                       ((is_lw || is_sw) && (64'(ea_q) >= 64'(MEM_DEPTH)));

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            datars_q <= '0;
            datart_q <= '0;
            ea_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    op_q  <= OpCode;
                    rs_q  <= rs;
                    rt_q  <= rt;
                    imm_q <= imm;
                end
                ST_RD: begin
                    datars_q <= rf_rdata_a;
                    datart_q <= rf_rdata_b;
                end
                ST_EX: ea_q <= datars_q + DATA_W'(sext(SEXT_W'(imm_q), IMM_W));
                ST_MEM: begin
                    err_q <= mem_fault;
                    // datart previews the WB value so it is visible alongside done.
                    if (!mem_fault && (is_lw || is_addi)) begin
                        if (rt_q == '0)  datart_q <= '0;
                        else if (is_lw)  datart_q <= mem_rdata;
                        else             datart_q <= ea_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign datars = datars_q;
    assign datart = datart_q;

    // ---------------- data memory ----------------
    assign mem_idx   = ea_q[MEM_AW-1:0];
    assign mem_rdata = mem[mem_idx];
    // Gated by rst_n so a reset edge during MEM aborts the store.
    assign mem_we    = rst_n && (state_q == ST_MEM) && is_sw && !mem_fault;

    // NOTE: the data memory has no reset; clearing a RAM array is not something
    // the storage can do in one cycle, and its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= datart_q;
    end

    // ---------------- register file ----------------
    assign rf_we = (state_q == ST_WB) && !err_q && (is_lw || is_addi);

    i_type_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs_q),
        .raddr_b_i (rt_q),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b),
        .we_i      (rf_we),
        .waddr_i   (rt_q),
        .wdata_i   (datart_q)
    );

endmodule

// File: tb/tb_i_type_lsu_mc.sv
// Directed self-checking bench for i_type_lsu_mc (default parameters).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_i_type_lsu_mc;

    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b000000;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [5:0]  OpCode;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        ready, done, err;
    logic [31:0] datars, datart;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i_type_lsu_mc dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ready  (ready),
        .OpCode (OpCode),
        .rs     (rs),
        .rt     (rt),
        .imm    (imm),
        .datars (datars),
        .datart (datart),
        .done   (done),
        .err    (err)
    );

    // Issues one instruction at the current falling edge (ready expected high),
    // waits for done, checks handshake timing and returns the outputs seen with done.
    // busy_start keeps start asserted with another instruction while the unit is busy.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [4:0] s, input logic [4:0] t,
                             input logic [15:0] i, input bit busy_start,
                             output logic [31:0] o_rs, output logic [31:0] o_rt,
                             output logic o_err);
        int n;
        bit seen;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL %s ready_before_accept: got %b want 1", name, ready);
        else n_pass++;
        start = 1'b1; OpCode = op; rs = s; rt = t; imm = i;
        @(negedge clk);
        if (busy_start) begin
            start = 1'b1; OpCode = T_ADDI; rs = 5'd0; rt = 5'd5; imm = 16'd99;
        end else begin
            start = 1'b0; OpCode = 6'($urandom); rs = 5'($urandom);
            rt = 5'($urandom); imm = 16'($urandom);
        end
        n_checks++;
        if (ready !== 1'b0) $display("FAIL %s ready_busy: got %b want 0", name, ready);
        else n_pass++;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        o_rs  = datars;
        o_rt  = datart;
        o_err = err;
        n_checks++;
        if (!seen || n != 3)
            $display("FAIL %s done_latency: got %0d edges (seen=%b) want 3", name, n, seen);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; OpCode = '0; rs = '0; rt = '0; imm = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (datars !== 32'd0) $display("FAIL reset_datars: got %h want 0", datars); else n_pass++;
        n_checks++; if (datart !== 32'd0) $display("FAIL reset_datart: got %h want 0", datart); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        logic [31:0] a, b; logic e;
        run_instr("addi_r3", T_ADDI, 5'd0, 5'd3, 16'd10, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd10) $display("FAIL addi_r3_datart: got %h want 0000000a", b); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL addi_r3_err: got %b want 0", e); else n_pass++;
        run_instr("addi_r9", T_ADDI, 5'd3, 5'd9, 16'hFFFD, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd10) $display("FAIL addi_r9_datars: got %h want 0000000a", a); else n_pass++;
        n_checks++; if (b !== 32'd7) $display("FAIL addi_r9_datart: got %h want 00000007", b); else n_pass++;
    endtask

    task automatic test_sw_lw();
        logic [31:0] a, b; logic e;
        run_instr("sw_17", T_SW, 5'd3, 5'd9, 16'd7, 1'b0, a, b, e);
        n_checks++; if (e !== 1'b0) $display("FAIL sw_17_err: got %b want 0", e); else n_pass++;
        n_checks++; if (b !== 32'd7) $display("FAIL sw_17_datart: got %h want 00000007", b); else n_pass++;
        run_instr("lw_17", T_LW, 5'd3, 5'd2, 16'd7, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd10) $display("FAIL lw_17_datars: got %h want 0000000a", a); else n_pass++;
        n_checks++; if (b !== 32'd7) $display("FAIL lw_17_datart: got %h want 00000007", b); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL lw_17_err: got %b want 0", e); else n_pass++;
        run_instr("addi_from_r2", T_ADDI, 5'd2, 5'd4, 16'd1, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd8) $display("FAIL r2_written: got %h want 00000008", b); else n_pass++;
        // rs == rt: store address 7+9 = 16 with the value 7 of R9.
        run_instr("sw_rs_eq_rt", T_SW, 5'd9, 5'd9, 16'd9, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd7 || b !== 32'd7) $display("FAIL sw_rs_eq_rt_reads: got %h/%h want 7/7", a, b); else n_pass++;
        run_instr("lw_16", T_LW, 5'd0, 5'd4, 16'd16, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd7) $display("FAIL lw_16_datart: got %h want 00000007", b); else n_pass++;
    endtask

    task automatic test_bounds();
        logic [31:0] a, b; logic e;
        run_instr("addi_r10", T_ADDI, 5'd0, 5'd10, 16'd300, 1'b0, a, b, e);
        run_instr("lw_300", T_LW, 5'd10, 5'd7, 16'd0, 1'b0, a, b, e);
        n_checks++; if (e !== 1'b1) $display("FAIL lw_300_err: got %b want 1", e); else n_pass++;
        run_instr("read_r7", T_ADDI, 5'd7, 5'd8, 16'd0, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd0) $display("FAIL r7_unchanged: got %h want 0", a); else n_pass++;
        run_instr("addi_r11", T_ADDI, 5'd0, 5'd11, 16'd255, 1'b0, a, b, e);
        run_instr("sw_255", T_SW, 5'd11, 5'd9, 16'd0, 1'b0, a, b, e);
        n_checks++; if (e !== 1'b0) $display("FAIL sw_255_err: got %b want 0", e); else n_pass++;
        run_instr("lw_255", T_LW, 5'd11, 5'd12, 16'd0, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd7 || e !== 1'b0) $display("FAIL lw_255: got %h err %b want 7 err 0", b, e); else n_pass++;
        run_instr("sw_256", T_SW, 5'd11, 5'd9, 16'd1, 1'b0, a, b, e);
        n_checks++; if (e !== 1'b1) $display("FAIL sw_256_err: got %b want 1", e); else n_pass++;
        // 10 + (-11) wraps to 0xFFFFFFFF, far above the memory.
        run_instr("lw_neg", T_LW, 5'd3, 5'd12, 16'hFFF5, 1'b0, a, b, e);
        n_checks++; if (e !== 1'b1) $display("FAIL lw_neg_err: got %b want 1", e); else n_pass++;
        run_instr("read_r12", T_ADDI, 5'd12, 5'd15, 16'd0, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd7) $display("FAIL r12_unchanged: got %h want 00000007", a); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [31:0] a, b; logic e;
        run_instr("illegal", T_BAD, 5'd3, 5'd3, 16'd1, 1'b1, a, b, e);
        n_checks++; if (e !== 1'b1) $display("FAIL illegal_err: got %b want 1", e); else n_pass++;
        run_instr("read_r5", T_ADDI, 5'd5, 5'd6, 16'd0, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd0) $display("FAIL busy_start_ignored: got %h want 0", a); else n_pass++;
        run_instr("read_r3", T_ADDI, 5'd3, 5'd6, 16'd0, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd10) $display("FAIL illegal_no_side_effect: got %h want 0000000a", a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; logic e;
        run_instr("b2b_1", T_ADDI, 5'd0, 5'd20, 16'd1, 1'b0, a, b, e);
        run_instr("b2b_2", T_ADDI, 5'd20, 5'd20, 16'd2, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd1 || b !== 32'd3) $display("FAIL b2b_2: got %h/%h want 1/3", a, b); else n_pass++;
        run_instr("b2b_3", T_ADDI, 5'd20, 5'd21, 16'hFFFC, 1'b0, a, b, e);
        n_checks++; if (b !== 32'hFFFF_FFFF) $display("FAIL b2b_wrap_neg: got %h want ffffffff", b); else n_pass++;
        run_instr("b2b_4", T_ADDI, 5'd21, 5'd22, 16'd1, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd0 || e !== 1'b0) $display("FAIL b2b_wrap_zero: got %h err %b want 0 err 0", b, e); else n_pass++;
    endtask

    task automatic test_r0();
        logic [31:0] a, b; logic e;
        run_instr("addi_r0", T_ADDI, 5'd0, 5'd0, 16'd5, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd0) $display("FAIL r0_datart: got %h want 0", b); else n_pass++;
        run_instr("read_r0", T_ADDI, 5'd0, 5'd13, 16'd1, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd0 || b !== 32'd1) $display("FAIL r0_stays_zero: got %h/%h want 0/1", a, b); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] a, b; logic e;
        run_instr("addi_r14", T_ADDI, 5'd0, 5'd14, 16'd42, 1'b0, a, b, e);
        run_instr("sw_20", T_SW, 5'd0, 5'd9, 16'd20, 1'b0, a, b, e);
        // SW R14,20(R0), reset asserted while the instruction sits in MEM.
        start = 1'b1; OpCode = T_SW; rs = 5'd0; rt = 5'd14; imm = 16'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done_1: got %b want 0", done); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done_2: got %b want 0", done); else n_pass++;
        run_instr("lw_20", T_LW, 5'd0, 5'd1, 16'd20, 1'b0, a, b, e);
        n_checks++; if (b !== 32'd7) $display("FAIL abort_no_mem_write: got %h want 00000007", b); else n_pass++;
        run_instr("read_r3_cleared", T_ADDI, 5'd3, 5'd6, 16'd0, 1'b0, a, b, e);
        n_checks++; if (a !== 32'd0) $display("FAIL reset_clears_regs: got %h want 0", a); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sw_lw();
        test_bounds();
        test_illegal();
        test_back_to_back();
        test_r0();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
